// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if -- start/busy/done handshake between the core control FSM and the
// iterative multiply/divide sequencer.
//
//   start      request, sampled by the sequencer only while it is idle
//   op         00 MUL, 01 UMULL, 10 SMULL, 11 UDIV
//   a, b       multiplicand/dividend, multiplier/divisor
//   busy       operation in flight
//   done       one-cycle pulse, results valid
//   result_hi  product upper half, or remainder for UDIV
//   result_lo  product lower half, or quotient for UDIV
//   divzero    UDIV with b==0, updated together with done
//
// Modports: master = control unit, slave = sequencer.
// -----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             divzero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_hi, result_lo, divzero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_hi, result_lo, divzero
  );
endinterface

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq -- iterative multiply/divide sequencer.
//
// Shift-add multiplier (MUL, UMULL, SMULL) and restoring divider (UDIV) that
// share one accumulator / shift register pair. One iteration per clock,
// WIDTH iterations, then a finish cycle that fixes the sign and registers the
// results. done pulses one cycle after the finish edge.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    muldiv_if slave modport (start/op/a/b in, busy/done/results out)
//
// Optional build macro MULDIV_EARLY_EXIT_EN: multiply ops leave RUN as soon
// as the remaining multiplier bits are all zero, aligning the partial product
// with one right shift. UDIV always runs the full length. Without the macro
// every op has a fixed latency of WIDTH+1.
// -----------------------------------------------------------------------------
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int              CW    = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b01,
    OP_SMULL = 2'b10,
    OP_UDIV  = 2'b11
  } op_t;

  state_t           state;
  op_t              op_q;
  logic             sign_q;
  logic [CW-1:0]    counter;

  // acc:   upper product half / partial remainder
  // mq:    multiplier, shifted out as product low bits enter from the top /
  //        dividend, shifted out at the top as quotient bits enter at the bottom
  // mcand: multiplicand / divisor
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] mcand;

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fix;
  logic               early_exit;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latches.
    mul_sum     = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
    // The shifted remainder needs WIDTH+1 bits: its top bit can be set when
    // the divisor is larger than 2^(WIDTH-1).
    div_shift   = {acc, mq[WIDTH-1]};
    div_diff    = div_shift - {1'b0, mcand};
    div_ge      = ~div_diff[WIDTH];          // no borrow => rem >= divisor
    product     = {acc, mq};
    product_fix = (op_q == OP_SMULL && sign_q) ? -product : product;
  end

`ifdef MULDIV_EARLY_EXIT_EN
  localparam logic [CW:0] ITERS = (CW + 1)'(WIDTH);

  logic [WIDTH-1:0]   mplr_mask;
  logic [CW:0]        remaining;
  logic [2*WIDTH-1:0] aligned;

  // After `counter` iterations only the low WIDTH-counter bits of mq are
  // still multiplier bits; the rest are already product bits.
  always_comb begin
    mplr_mask  = {WIDTH{1'b1}} >> counter;
    remaining  = ITERS - {1'b0, counter};
    aligned    = product >> remaining;
    early_exit = (op_q != OP_UDIV) && ((mq & mplr_mask) == '0);
  end
`else
  assign early_exit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result_hi <= '0;
      bus.result_lo <= '0;
      bus.divzero   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            counter  <= '0;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          if (early_exit || counter == LAST) begin
            state <= FIN;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        FIN: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          if (op_q == OP_UDIV) begin
            bus.result_hi <= acc;
            bus.result_lo <= mq;
          end else begin
            bus.result_hi <= product_fix[2*WIDTH-1:WIDTH];
            bus.result_lo <= product_fix[WIDTH-1:0];
          end
          bus.divzero <= (op_q == OP_UDIV) && (mcand == '0);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand / accumulator registers
  // ---------------------------------------------------------------------------
  // NOTE: datapath registers carry no reset; they are always loaded in IDLE
  // before RUN reads them, and a reset only needs to return the FSM to IDLE.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (bus.start) begin
          op_q <= op_t'(bus.op);
          acc  <= '0;
          case (op_t'(bus.op))
            OP_SMULL: begin
              // |most negative| wraps to itself, which is correct as unsigned.
              sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              mcand  <= bus.a[WIDTH-1] ? -bus.a : bus.a;
              mq     <= bus.b[WIDTH-1] ? -bus.b : bus.b;
            end
            OP_UDIV: begin
              sign_q <= 1'b0;
              mcand  <= bus.b;
              mq     <= bus.a;
            end
            default: begin
              sign_q <= 1'b0;
              mcand  <= bus.a;
              mq     <= bus.b;
            end
          endcase
        end
      end
      RUN: begin
`ifdef MULDIV_EARLY_EXIT_EN
        if (early_exit) begin
          {acc, mq} <= aligned;
        end else
`endif
        if (op_q == OP_UDIV) begin
          acc <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          mq  <= {mq[WIDTH-2:0], div_ge};
        end else begin
          // Shift {carry, acc, mq} right by one; the add carry enters the MSB.
          acc <= mul_sum[WIDTH:1];
          mq  <= {mul_sum[0], mq[WIDTH-1:1]};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq -- self-checking bench for muldiv_seq (WIDTH=32).
// Directed cases plus randomized ops, compared against a plain-arithmetic
// reference model. Honors MULDIV_EARLY_EXIT_EN for expected latency.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int busy_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {divzero, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [63:0] p;
    longint sx, sy;
    case (o)
      2'b10: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = 64'(sx * sy);
      end
      2'b11:   p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: p = {32'b0, x} * {32'b0, y};
    endcase
    return {(o == 2'b11) && (y == 0), p};
  endfunction

  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] y);
`ifdef MULDIV_EARLY_EXIT_EN
    logic [31:0] m;
    int bits = 0;
    if (o == 2'b11) return W + 1;
    m = (o == 2'b10 && y[31]) ? -y : y;
    for (int i = 0; i < W; i++) if (m[i]) bits = i + 1;
    return (bits == W) ? W + 1 : bits + 2;
`else
    return W + 1 + 0 * int'(o) + 0 * int'(y[0]);
`endif
  endfunction

  task automatic tick();
    if (bus.busy) busy_cnt++;
    @(posedge clk);
    #1;
    lat++;
  endtask

  // Presents start for exactly one edge (edge 0), then drops it.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat       = 0;
    busy_cnt  = 0;
  endtask

  task automatic wait_done(input string tag);
    while (!bus.done && lat < 100) tick();
    check({tag, " done_seen"}, 64'(bus.done), 64'd1);
  endtask

  task automatic check_result(input string tag, input logic [1:0] o,
                              input logic [31:0] x, input logic [31:0] y);
    logic [64:0] m;
    m = model(o, x, y);
    check({tag, " hi"}, 64'(bus.result_hi), 64'(m[63:32]));
    check({tag, " lo"}, 64'(bus.result_lo), 64'(m[31:0]));
    check({tag, " divzero"}, 64'(bus.divzero), 64'(m[64]));
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y);
    issue(o, x, y);
    wait_done(tag);
    check({tag, " latency"}, 64'(lat), 64'(exp_latency(o, y)));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_latency(o, y)));
    check({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
    check_result(tag, o, x, y);
    tick();
    check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int dones;
    logic [1:0]  o;
    logic [31:0] x, y;

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hi", 64'(bus.result_hi), 64'd0);
    check("reset lo", 64'(bus.result_lo), 64'd0);
    check("reset divzero", 64'(bus.divzero), 64'd0);

    // Directed cases, with spec constants as well as the model.
    run_op("umull_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("umull_max hi_const", 64'(bus.result_hi), 64'hFFFF_FFFE);
    run_op("smull_neg2x3", 2'b10, 32'hFFFF_FFFE, 32'h0000_0003);
    check("smull_neg2x3 lo_const", 64'(bus.result_lo), 64'hFFFF_FFFA);
    run_op("smull_minxmin", 2'b10, 32'h8000_0000, 32'h8000_0000);
    check("smull_minxmin hi_const", 64'(bus.result_hi), 64'h4000_0000);
    run_op("udiv_100_7", 2'b11, 32'd100, 32'd7);
    check("udiv_100_7 lo_const", 64'(bus.result_lo), 64'd14);
    run_op("udiv_by_zero", 2'b11, 32'h1234_5678, 32'd0);
    check("udiv_by_zero dz_const", 64'(bus.divzero), 64'd1);
    run_op("udiv_big_divisor", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op("mul_b0", 2'b00, 32'hDEAD_BEEF, 32'd0);
    run_op("mul_b3", 2'b00, 32'h1234_5678, 32'd3);

    // start while busy is ignored
    issue(2'b00, 32'd5, 32'd6);
    repeat (4) tick();
    bus.start = 1'b1;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    tick();
    bus.start = 1'b0;
    wait_done("busy_ignore");
    check("busy_ignore lo", 64'(bus.result_lo), 64'd30);
    check("busy_ignore latency", 64'(lat), 64'(exp_latency(2'b00, 32'd6)));

    // Back-to-back: start is asserted in the done cycle with new operands.
    issue(2'b01, 32'h0001_0000, 32'h0001_0000);
    wait_done("b2b_first");
    check_result("b2b_first", 2'b01, 32'h0001_0000, 32'h0001_0000);
    issue(2'b11, 32'd9, 32'd2);
    wait_done("b2b_second");
    check("b2b_second latency", 64'(lat), 64'(W + 1));
    check("b2b_second lo", 64'(bus.result_lo), 64'd4);
    check("b2b_second hi", 64'(bus.result_hi), 64'd1);

    // Reset in RUN aborts with no done.
    issue(2'b01, 32'h0BAD_F00D, 32'hFFFF_FFFF);
    repeat (10) tick();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    check("abort hi", 64'(bus.result_hi), 64'd0);
    check("abort lo", 64'(bus.result_lo), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("abort no_done", 64'(dones), 64'd0);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 5))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 255));
        2:       y = 32'h8000_0000;
        default: y = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), o, x, y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
